// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Supervises the fabric PLL from the reference clock domain: pulses the PLL
// reset, waits for lock, qualifies lock stability before releasing the system,
// re-resets on lock loss and gives up after a bounded number of timeouts.
//
// Ports:
//   refclk        reference clock, sole clock of the block
//   rst           asynchronous active-high reset
//   locked        PLL locked indication, asynchronous to refclk
//   retry         single-cycle request to leave the failed state
//   pll_rst       reset to the PLL
//   ready         PLL output qualified stable
//   fail          lock attempts exhausted
//   lock_lost     one-cycle pulse when lock drops while ready
//   relock_count  saturating count of lock_lost events
//   state         FSM state code (debug)
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 3,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    input  logic             retry,
    output logic             pll_rst,
    output logic             ready,
    output logic             fail,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count,
    output logic [2:0]       state
);

    // Timer is shared by all states, so it is sized for the longest interval.
    localparam int unsigned TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
    localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned RW     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_READY  = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t          fsm;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   retry_cnt;
    logic            locked_meta;
    logic            locked_s;

    // Two-flop synchronizer for the asynchronous PLL lock indication.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= locked;
            locked_s    <= locked_meta;
        end
    end

    // Supervisor FSM; every output is updated together with the state so the
    // output values always match the state they belong to.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            fsm          <= S_RESET;
            timer        <= '0;
            retry_cnt    <= '0;
            pll_rst      <= 1'b1;
            ready        <= 1'b0;
            fail         <= 1'b0;
            lock_lost    <= 1'b0;
            relock_count <= '0;
        end else begin
            lock_lost <= 1'b0;
            unique case (fsm)
                S_RESET: begin
                    if (timer == RST_LAST) begin
                        fsm     <= S_WAIT;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_WAIT: begin
                    if (locked_s) begin
                        fsm   <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        if (retry_cnt == RETRY_MAX) begin
                            fsm  <= S_FAIL;
                            fail <= 1'b1;
                        end else begin
                            fsm       <= S_RESET;
                            retry_cnt <= retry_cnt + RW'(1);
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_STABLE: begin
                    // A dropout during qualification restarts the wait but is
                    // not a relock event.
                    if (!locked_s) begin
                        fsm   <= S_WAIT;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        fsm       <= S_READY;
                        timer     <= '0;
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_READY: begin
                    if (!locked_s) begin
                        fsm       <= S_RESET;
                        timer     <= '0;
                        ready     <= 1'b0;
                        pll_rst   <= 1'b1;
                        lock_lost <= 1'b1;
                        if (relock_count != '1) begin
                            relock_count <= relock_count + CNT_W'(1);
                        end
                    end
                end
                S_FAIL: begin
                    if (retry) begin
                        fsm       <= S_RESET;
                        timer     <= '0;
                        retry_cnt <= '0;
                        fail      <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encodings recover through a fresh PLL reset.
                    fsm     <= S_RESET;
                    timer   <= '0;
                    pll_rst <= 1'b1;
                    ready   <= 1'b0;
                    fail    <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor. Stimulus pushes expected output
// vectors tagged with the refclk cycle they belong to; a monitor on the falling
// edge pops and compares them, and checks the output invariants every cycle.
module tb_pll_lock_supervisor;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned VW    = 7 + CNT_W;

    logic             refclk = 1'b0;
    logic             rst    = 1'b1;
    logic             locked = 1'b0;
    logic             retry  = 1'b0;
    logic             pll_rst;
    logic             ready;
    logic             fail;
    logic             lock_lost;
    logic [CNT_W-1:0] relock_count;
    logic [2:0]       state;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (2),
        .CNT_W        (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .retry       (retry),
        .pll_rst     (pll_rst),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .relock_count(relock_count),
        .state       (state)
    );

    always #5 refclk = ~refclk;

    // Number of rising edges seen so far; expectations are tagged with it.
    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int               tag;
        logic [2:0]       st;
        logic             ll;
        logic [CNT_W-1:0] rc;
        string            name;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int tag, input logic [2:0] st, input logic ll,
                             input logic [CNT_W-1:0] rc, input string name);
        exp_t e;
        e.tag  = tag;
        e.st   = st;
        e.ll   = ll;
        e.rc   = rc;
        e.name = name;
        sb.push_back(e);
    endtask

    // Expected {state, pll_rst, ready, fail, lock_lost, relock_count}.
    function automatic logic [VW-1:0] pack_exp(input exp_t e);
        logic pr, rdy, fl;
        pr  = (e.st == 3'd0) || (e.st == 3'd4);
        rdy = (e.st == 3'd3);
        fl  = (e.st == 3'd4);
        return {e.st, pr, rdy, fl, e.ll, e.rc};
    endfunction

    always @(negedge refclk) begin : monitor
        exp_t            e;
        logic [VW-1:0]   act;
        logic [VW-1:0]   expv;
        act = {state, pll_rst, ready, fail, lock_lost, relock_count};
        n_tests++;
        if ((ready & fail) !== 1'b0 || (pll_rst & ready) !== 1'b0 ||
            (lock_lost === 1'b1 && state !== 3'd0)) begin
            n_fail++;
            $display("FAIL invariant: got {st,pr,rdy,fl,ll,rc}=%b at cycle %0d", act, cyc);
        end
        while (sb.size() != 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            n_tests++;
            expv = pack_exp(e);
            if (e.tag < cyc) begin
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked (now %0d)", e.name, e.tag, cyc);
            end else if (act !== expv) begin
                n_fail++;
                $display("FAIL %s: got {st,pr,rdy,fl,ll,rc}=%b want %b at cycle %0d",
                         e.name, act, expv, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) tick(1);
    endtask

    // Pulse rst (called 1 time unit after an edge); returns the cycle of S_WAIT entry.
    task automatic do_reset(output int w);
        int a, b;
        locked = 1'b0;
        retry  = 1'b0;
        rst    = 1'b1;
        a = cyc;
        expect_at(a, 3'd0, 1'b0, '0, "rst_async");
        tick(2);
        b = cyc;
        expect_at(b, 3'd0, 1'b0, '0, "rst_held");
        rst = 1'b0;
        expect_at(b + 1, 3'd0, 1'b0, '0, "pll_rst_c1");
        expect_at(b + 3, 3'd0, 1'b0, '0, "pll_rst_c3");
        expect_at(b + 4, 3'd1, 1'b0, '0, "pll_rst_fall");
        w = b + 4;
    endtask

    // From S_READY: drop lock, check the loss handling, then requalify to S_READY.
    task automatic lose_requal(input logic [CNT_W-1:0] prev, input logic [CNT_W-1:0] nxt,
                               input string name);
        int d, l;
        d = cyc;
        locked = 1'b0;
        expect_at(d + 2, 3'd3, 1'b0, prev, {name, "_still_ready"});
        expect_at(d + 3, 3'd0, 1'b1, nxt,  {name, "_lock_lost"});
        expect_at(d + 4, 3'd0, 1'b0, nxt,  {name, "_pulse_end"});
        expect_at(d + 6, 3'd0, 1'b0, nxt,  {name, "_reset_c4"});
        expect_at(d + 7, 3'd1, 1'b0, nxt,  {name, "_reset_done"});
        tick_to(d + 8);
        l = cyc;
        locked = 1'b1;
        expect_at(l + 2,  3'd1, 1'b0, nxt, {name, "_wait"});
        expect_at(l + 3,  3'd2, 1'b0, nxt, {name, "_stable"});
        expect_at(l + 10, 3'd2, 1'b0, nxt, {name, "_not_ready"});
        expect_at(l + 11, 3'd3, 1'b0, nxt, {name, "_ready"});
        tick_to(l + 12);
    endtask

    // Three attempts (reset 4 + wait 20 each) then S_FAIL, starting at reset cycle r0.
    task automatic expect_budget(input int r0, input bit first_done, input string name);
        for (int k = 0; k < 3; k++) begin
            int r;
            r = r0 + 24 * k;
            if (!(k == 0 && first_done)) begin
                expect_at(r,     3'd0, 1'b0, '0, {name, "_reset_start"});
                expect_at(r + 3, 3'd0, 1'b0, '0, {name, "_reset_end"});
                expect_at(r + 4, 3'd1, 1'b0, '0, {name, "_wait_start"});
            end
            expect_at(r + 23, 3'd1, 1'b0, '0, {name, "_wait_end"});
        end
        expect_at(r0 + 72, 3'd4, 1'b0, '0, {name, "_fail"});
    endtask

    initial begin : stim
        int w, l, b, p;
        tick(1);

        // Nominal bring-up; a retry pulse in S_WAIT must be ignored.
        do_reset(w);
        tick_to(w + 1);
        retry = 1'b1;
        expect_at(w + 2, 3'd1, 1'b0, '0, "t1_retry_ignored");
        tick(1);
        retry = 1'b0;
        tick_to(w + 3);
        l = cyc;
        locked = 1'b1;
        // ready follows 2 sync cycles + 8 qualification cycles after the first sampling edge
        expect_at(l + 2,  3'd1, 1'b0, '0, "t1_wait");
        expect_at(l + 3,  3'd2, 1'b0, '0, "t1_stable");
        expect_at(l + 10, 3'd2, 1'b0, '0, "t1_not_ready");
        expect_at(l + 11, 3'd3, 1'b0, '0, "t1_ready");
        tick_to(l + 13);

        // Loss of lock while ready, then saturation of relock_count.
        lose_requal(2'd0, 2'd1, "t3");
        lose_requal(2'd1, 2'd2, "sat2");
        lose_requal(2'd2, 2'd3, "sat3");
        lose_requal(2'd3, 2'd3, "sat4");
        lose_requal(2'd3, 2'd3, "sat5");

        // Lock glitch during qualification.
        do_reset(w);
        tick_to(w + 3);
        l = cyc;
        locked = 1'b1;
        expect_at(l + 3, 3'd2, 1'b0, '0, "t2_stable");
        tick_to(l + 5);
        locked = 1'b0;
        tick_to(l + 6);
        locked = 1'b1;
        expect_at(l + 7, 3'd2, 1'b0, '0, "t2_stable_late");
        expect_at(l + 8, 3'd1, 1'b0, '0, "t2_back_to_wait");
        for (int i = 9; i <= 16; i++) expect_at(l + i, 3'd2, 1'b0, '0, "t2_requal");
        expect_at(l + 17, 3'd3, 1'b0, '0, "t2_ready");
        tick_to(l + 18);

        // Exhausted retries, then retry restores a full budget.
        do_reset(w);
        b = w - 4;
        expect_budget(b, 1'b1, "t4a");
        expect_at(b + 102, 3'd4, 1'b0, '0, "t4_fail_held");
        tick_to(b + 103);
        p = cyc;
        retry = 1'b1;
        expect_budget(p + 1, 1'b0, "t4b");
        tick(1);
        retry = 1'b0;
        tick_to(p + 74);

        // Asynchronous reset mid-S_STABLE.
        do_reset(w);
        tick_to(w + 3);
        l = cyc;
        locked = 1'b1;
        expect_at(l + 3, 3'd2, 1'b0, '0, "t6_stable");
        tick_to(l + 5);
        #1;
        rst = 1'b1;
        expect_at(cyc, 3'd0, 1'b0, '0, "t6_async_stable");
        tick(1);

        // Asynchronous reset mid-S_READY with a nonzero relock_count.
        do_reset(w);
        tick_to(w + 3);
        l = cyc;
        locked = 1'b1;
        expect_at(l + 11, 3'd3, 1'b0, '0, "t6_ready");
        tick_to(l + 13);
        lose_requal(2'd0, 2'd1, "t6");
        #1;
        rst = 1'b1;
        expect_at(cyc, 3'd0, 1'b0, '0, "t6_async_ready");
        tick(2);
        rst = 1'b0;

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
